// File: rtl/cmp_modulo_updown.sv
// cmp_modulo_updown
//   Runtime-programmable modulo counter for timer and display digit chains.
//   Counts 0..modulo_i up or down. At a bound it either wraps or saturates,
//   and it supports a synchronous load that is clamped to modulo_i.
//   tc_o is combinational so a chain can feed tc_o of one stage straight into
//   en_i of the next stage.
//
//   Optional feature: define CMP_WRAP_COUNT_EN to add the wrapCnt_o port and
//   its register. wrapCnt_o counts wrap events and rolls over at its width.
//
// Ports
//   clk_i       clock, rising edge
//   nReset_i    synchronous reset, active-high (the name is historical)
//   en_i        count enable for this cycle
//   up_i        1 = increment, 0 = decrement
//   sat_i       1 = saturate at the bound, 0 = wrap
//   load_i      synchronous load of loadVal_i (has priority over en_i)
//   loadVal_i   value to load, clamped to modulo_i
//   modulo_i    maximum count M; the period is M+1
//   S_o         current count (registered)
//   tc_o        terminal count (combinational)
//   wrap_o      one-cycle pulse, asserted with the post-wrap count
//   atBound_o   high while the counter is held at a bound by saturation
//   wrapCnt_o   wrap event counter (only with CMP_WRAP_COUNT_EN)
module cmp_modulo_updown #(
    parameter int BUS_SIZE      = 8,
    parameter int WRAP_CNT_SIZE = 8
) (
    input  logic                     clk_i,
    input  logic                     nReset_i,
    input  logic                     en_i,
    input  logic                     up_i,
    input  logic                     sat_i,
    input  logic                     load_i,
    input  logic [BUS_SIZE-1:0]      loadVal_i,
    input  logic [BUS_SIZE-1:0]      modulo_i,
    output logic [BUS_SIZE-1:0]      S_o,
    output logic                     tc_o,
    output logic                     wrap_o,
`ifdef CMP_WRAP_COUNT_EN
    output logic                     atBound_o,
    output logic [WRAP_CNT_SIZE-1:0] wrapCnt_o
`else
    output logic                     atBound_o
`endif
);

    logic [BUS_SIZE-1:0] s_q, s_d;
    logic                wrap_q, wrap_d;
    logic                at_bound_q, at_bound_d;
    logic                at_max, at_zero;

    // ">=" rather than "==" so that a modulo lowered below the current count
    // still counts as the top bound.
    assign at_max  = (s_q >= modulo_i);
    assign at_zero = (s_q == '0);

    assign tc_o = en_i & ((up_i & at_max) | (~up_i & at_zero));

    // Next-state logic. The pulse outputs default low, so any cycle without
    // a wrap or saturation event clears them.
    always_comb begin
        s_d        = s_q;
        wrap_d     = 1'b0;
        at_bound_d = 1'b0;
        if (load_i) begin
            s_d = (loadVal_i > modulo_i) ? modulo_i : loadVal_i;
        end else if (en_i) begin
            if (up_i) begin
                if (!at_max) begin
                    // This cannot overflow: s_q at all-ones implies at_max.
                    s_d = s_q + 1'b1;
                end else if (sat_i) begin
                    s_d        = modulo_i;
                    at_bound_d = 1'b1;
                end else begin
                    s_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (s_q > modulo_i) begin
                    // The count sits above a modulo that was lowered. Pull it
                    // back into range. This is neither a wrap nor a saturation.
                    s_d = modulo_i;
                end else if (!at_zero) begin
                    s_d = s_q - 1'b1;
                end else if (sat_i) begin
                    s_d        = '0;
                    at_bound_d = 1'b1;
                end else begin
                    s_d    = modulo_i;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (nReset_i) begin
            s_q        <= '0;
            wrap_q     <= 1'b0;
            at_bound_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            wrap_q     <= wrap_d;
            at_bound_q <= at_bound_d;
        end
    end

`ifdef CMP_WRAP_COUNT_EN
    logic [WRAP_CNT_SIZE-1:0] wrap_cnt_q, wrap_cnt_d;

    // A load never sets wrap_d, so a load leaves the wrap count unchanged.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_d) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (nReset_i) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrapCnt_o = wrap_cnt_q;
`endif

    assign S_o       = s_q;
    assign wrap_o    = wrap_q;
    assign atBound_o = at_bound_q;

endmodule

// File: tb/tb_cmp_modulo_updown.sv
module tb_cmp_modulo_updown;

    localparam int BW = 8;
    localparam int WW = 8;

    logic          clk_i = 1'b0;
    logic          nReset_i, en_i, up_i, sat_i, load_i;
    logic [BW-1:0] loadVal_i, modulo_i, S_o;
    logic          tc_o, wrap_o, atBound_o;

    // Signals for the two-stage cascade.
    logic          c_rst, c_en;
    logic [BW-1:0] c_mod, c_zero, lo_s, hi_s;
    logic          lo_tc, lo_wrap, lo_ab, hi_tc, hi_wrap, hi_ab;

`ifdef CMP_WRAP_COUNT_EN
    logic [WW-1:0] wrapCnt_o, lo_wc, hi_wc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    cmp_modulo_updown #(.BUS_SIZE(BW), .WRAP_CNT_SIZE(WW)) dut (
        .clk_i(clk_i), .nReset_i(nReset_i), .en_i(en_i), .up_i(up_i),
        .sat_i(sat_i), .load_i(load_i), .loadVal_i(loadVal_i),
        .modulo_i(modulo_i), .S_o(S_o), .tc_o(tc_o), .wrap_o(wrap_o),
`ifdef CMP_WRAP_COUNT_EN
        .atBound_o(atBound_o), .wrapCnt_o(wrapCnt_o)
`else
        .atBound_o(atBound_o)
`endif
    );

    cmp_modulo_updown #(.BUS_SIZE(BW), .WRAP_CNT_SIZE(WW)) u_lo (
        .clk_i(clk_i), .nReset_i(c_rst), .en_i(c_en), .up_i(1'b1),
        .sat_i(1'b0), .load_i(1'b0), .loadVal_i(c_zero),
        .modulo_i(c_mod), .S_o(lo_s), .tc_o(lo_tc), .wrap_o(lo_wrap),
`ifdef CMP_WRAP_COUNT_EN
        .atBound_o(lo_ab), .wrapCnt_o(lo_wc)
`else
        .atBound_o(lo_ab)
`endif
    );

    cmp_modulo_updown #(.BUS_SIZE(BW), .WRAP_CNT_SIZE(WW)) u_hi (
        .clk_i(clk_i), .nReset_i(c_rst), .en_i(lo_tc), .up_i(1'b1),
        .sat_i(1'b0), .load_i(1'b0), .loadVal_i(c_zero),
        .modulo_i(c_mod), .S_o(hi_s), .tc_o(hi_tc), .wrap_o(hi_wrap),
`ifdef CMP_WRAP_COUNT_EN
        .atBound_o(hi_ab), .wrapCnt_o(hi_wc)
`else
        .atBound_o(hi_ab)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Step one clock edge and settle. Inputs change and outputs are sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        nReset_i = 1'b1;
        tick();
        nReset_i = 1'b0;
    endtask

    initial begin
        int up_exp [12];
        int dn_exp [6];
        int lo_m, hi_m;

        nReset_i = 1'b1; en_i = 1'b0; up_i = 1'b1; sat_i = 1'b0;
        load_i = 1'b0; loadVal_i = '0; modulo_i = 8'd9;
        c_rst = 1'b1; c_en = 1'b0; c_mod = 8'd9; c_zero = '0;

        // Reset state
        tick();
        chk("rst_S", S_o, 0);
        chk("rst_wrap", wrap_o, 0);
        chk("rst_atBound", atBound_o, 0);
`ifdef CMP_WRAP_COUNT_EN
        chk("rst_wrapCnt", wrapCnt_o, 0);
`endif

        // Count up and wrap with M=9: S goes 0..9, 0, 1
        for (int i = 0; i < 12; i++) up_exp[i] = (i <= 9) ? i : i - 10;
        nReset_i = 1'b0; en_i = 1'b1; up_i = 1'b1; sat_i = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("up_S[%0d]", i), S_o, up_exp[i]);
            chk($sformatf("up_tc[%0d]", i), tc_o, (i == 9) ? 1 : 0);
            chk($sformatf("up_wrap[%0d]", i), wrap_o, (i == 10) ? 1 : 0);
            tick();
        end
`ifdef CMP_WRAP_COUNT_EN
        chk("up_wrapCnt", wrapCnt_o, 1);
`endif

        // Count down and saturate: load 3, then S goes 3, 2, 1, 0, 0, 0
        dn_exp = '{3, 2, 1, 0, 0, 0};
        en_i = 1'b1; load_i = 1'b1; loadVal_i = 8'd3;
        tick();
        load_i = 1'b0; up_i = 1'b0; sat_i = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("dn_S[%0d]", i), S_o, dn_exp[i]);
            chk($sformatf("dn_atBound[%0d]", i), atBound_o, (i >= 4) ? 1 : 0);
            chk($sformatf("dn_wrap[%0d]", i), wrap_o, 0);
            chk($sformatf("dn_tc[%0d]", i), tc_o, (i >= 3) ? 1 : 0);
            tick();
        end
        en_i = 1'b0;
        tick();
        chk("dn_atBound_clr", atBound_o, 0);

        // Saturate at the top bound
        load_i = 1'b1; loadVal_i = 8'd9; modulo_i = 8'd9;
        tick();
        load_i = 1'b0; en_i = 1'b1; up_i = 1'b1; sat_i = 1'b1;
        tick();
        chk("upsat_S", S_o, 9);
        chk("upsat_atBound", atBound_o, 1);
        chk("upsat_wrap", wrap_o, 0);

        // Lower M at runtime while counting up: the counter wraps
        do_reset();
        modulo_i = 8'd9; up_i = 1'b1; sat_i = 1'b0; en_i = 1'b1;
        repeat (7) tick();
        chk("mod_up_S7", S_o, 7);
        modulo_i = 8'd4;
        #1;
        chk("mod_up_tc", tc_o, 1);
        tick();
        chk("mod_up_S", S_o, 0);
        chk("mod_up_wrap", wrap_o, 1);

        // Lower M at runtime while counting down: the count is clamped
        modulo_i = 8'd9; load_i = 1'b1; loadVal_i = 8'd7;
        tick();
        load_i = 1'b0; modulo_i = 8'd4; up_i = 1'b0; sat_i = 1'b0;
        tick();
        chk("mod_dn_S", S_o, 4);
        chk("mod_dn_wrap", wrap_o, 0);
        chk("mod_dn_atBound", atBound_o, 0);

        // Load clamp, and priority of load and reset over counting
        loadVal_i = 8'd200; modulo_i = 8'd50; load_i = 1'b1; en_i = 1'b1; up_i = 1'b1;
        tick();
        chk("load_clamp_S", S_o, 50);
        nReset_i = 1'b1;
        tick();
        chk("rst_over_load_S", S_o, 0);
        nReset_i = 1'b0; load_i = 1'b0;

        // M=0: S stays 0 and wrap pulses on every enabled cycle
        modulo_i = 8'd0; sat_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
        #1;
        chk("m0_tc_first", tc_o, 1);
        chk("m0_wrap_first", wrap_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("m0_S[%0d]", i), S_o, 0);
            chk($sformatf("m0_wrap[%0d]", i), wrap_o, 1);
            chk($sformatf("m0_tc[%0d]", i), tc_o, 1);
        end
        en_i = 1'b0;
        #1;
        chk("m0_tc_off", tc_o, 0);
        tick();
        chk("m0_wrap_off", wrap_o, 0);

        // Cascade two M=9 stages for 25 cycles
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_en = 1'b1;
        lo_m = 0; hi_m = 0;
        for (int i = 0; i < 25; i++) begin
            if (lo_m == 9) begin
                lo_m = 0;
                hi_m = (hi_m + 1) % 10;
            end else begin
                lo_m = lo_m + 1;
            end
            tick();
            chk($sformatf("casc_hi[%0d]", i), hi_s, hi_m);
        end
        chk("casc_lo_final", lo_s, 5);
        chk("casc_hi_final", hi_s, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
